obi_ahb_master_bridge: RTL
==========================

# obi_ahb_master_bridge

Converts one OBI-style core port (req/gnt/rvalid, as driven by cv32e40p instruction or data interface) into a single-master AHB-Lite transfer stream. Sits directly downstream of the core inside the testbench wrapper, replacing the direct core-to-RAM connection. The AHB side feeds the interconnect/decoder in front of RAM and the stdout/exit peripherals. Two instances are used: one for instruction fetch, one for data.

## Interface
- IS_INSTR, 0: 1 for the instruction port (HPROT[0]=0 opcode), 0 for data (HPROT[0]=1).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant; address phase accepted.
- addr_i  in  32  byte address.
- we_i  in  1  write enable; tied 0 on the instruction instance.
- be_i  in  4  byte enables; tied 4'b1111 on the instruction instance.
- wdata_i  in  32  write data, valid with req_i.
- rvalid_o  out  1  response valid, one cycle per granted request.
- rdata_o  out  32  read data, valid with rvalid_o; 0 on writes.
- err_o  out  1  AHB error response, valid with rvalid_o.
- haddr_o  out  32; htrans_o  out  2; hwrite_o  out  1; hsize_o  out  3; hburst_o  out  3 (constant SINGLE); hprot_o  out  4 (4'b0011 data, 4'b0010 instr).
- hwdata_o  out  32; hrdata_i  in  32; hready_i  in  1; hresp_i  in  1.

## Operation
- States: IDLE, DATA, RESP.
- IDLE: htrans_o=NONSEQ whenever req_i=1. haddr/hwrite/hsize come combinationally from addr_i/we_i/be_i. gnt_o=req_i & hready_i. On grant: latch we, wdata, byte offset; go to DATA. Without grant: stay IDLE; the master holds req and address stable.
- DATA: htrans_o=IDLE; hwdata_o=latched wdata. Wait while hready_i=0.
  - hready_i=1: capture hrdata_i (reads only; else 0) and hresp_i; go to RESP.
- RESP: rvalid_o=1 with the captured rdata and err. Behaves as IDLE for the next request: a new req_i may be granted in this cycle and go directly to DATA. Otherwise go to IDLE.
- Byte-enable decode, giving hsize and haddr[1:0]; haddr[31:2]=addr_i[31:2]:
  - 0001/0010/0100/1000: byte, offset 0/1/2/3.
  - 0011/1100: half, offset 0/2.
  - 1111 and every other pattern: word, offset 0.
- Read data is passed unshifted, on full-word lanes; the core extracts the bytes it needs.
- Error: the two-cycle AHB ERROR response is handled naturally. The first cycle (hready=0, hresp=1) waits; the second completes with err_o=1. The bridge never overlaps address phases, so no cancellation is needed.
- At most one outstanding transfer.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, htrans_o=IDLE, haddr_o=0, hwrite_o=0, hsize_o=word, hwdata_o=0. State goes to IDLE.
- Zero-wait latency: gnt at cycle N, data phase at N+1, rvalid at N+2.
- Back-to-back throughput: one transfer per 2 cycles.
- Each wait state adds one cycle.
- rst_i asserted mid-transfer: state goes to IDLE at the next edge; the pending response is dropped and no rvalid is issued. The bench must not mix this with slaves that still hold a data phase.
- req_i deasserted in IDLE without grant: no AHB transfer is issued.
- hready_i low in IDLE: the AHB address is driven but gnt_o=0; the address phase repeats until hready_i=1.

## Structure
- Shared package ahb_pkg holds:
  - htrans_t (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
  - hsize constants BYTE=000, HALF=001, WORD=010.
  - HBURST_SINGLE=000.
  - the bridge state enum.
- Sub-module obi_ahb_size_decode: combinational be[3:0] to {hsize, offset[1:0]}.

## Test plan
- Read, zero wait: addr=0x80, be=1111, hrdata=0xDEADBEEF.
  - Required: gnt at N; htrans NONSEQ, hsize WORD, haddr 0x80; rvalid at N+2 with rdata 0xDEADBEEF, err 0.
- Byte write: addr=0x1003, be=1000, wdata=0xAB000000.
  - Required: haddr 0x1003, hsize BYTE, hwrite 1; hwdata 0xAB000000 in the data phase.
- Wait states: hready low for 3 data-phase cycles.
  - Required: rvalid at N+5; hwdata held stable throughout.
- Error response: hresp=1 for 2 cycles, hready 0 then 1.
  - Required: rvalid with err_o=1, rdata 0.
- Back-to-back: reads to 0x0, 0x4, 0x8 with req held high.
  - Required: grants at N, N+2, N+4; rvalid at N+2, N+4, N+6, in order.
- Reset mid-transfer: rst_i pulsed during DATA.
  - Required: next cycle all outputs at reset values and no rvalid; the following request completes normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the OBI-to-AHB bridge state type.
//   htrans_t       - AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE_*        - transfer size codes used by the bridge
//   HBURST_SINGLE  - the only burst type the bridge issues
//   bridge_state_t - bridge FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_DATA = 2'd1,
    BR_RESP = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/obi_ahb_size_decode.sv
// obi_ahb_size_decode: maps OBI byte enables onto an AHB transfer size and
// the low two address bits.
//   be_i     in  4  byte enables
//   hsize_o  out 3  AHB HSIZE
//   offset_o out 2  byte offset inside the word (becomes haddr[1:0])
// Single bytes and aligned halves get their natural size; every other
// pattern (including 1111) is issued as an aligned word.
module obi_ahb_size_decode
  import ahb_pkg::*;
(
  input  logic [3:0] be_i,
  output logic [2:0] hsize_o,
  output logic [1:0] offset_o
);

  always_comb begin
    hsize_o  = HSIZE_WORD;
    offset_o = 2'd0;
    case (be_i)
      4'b0001: begin hsize_o = HSIZE_BYTE; offset_o = 2'd0; end
      4'b0010: begin hsize_o = HSIZE_BYTE; offset_o = 2'd1; end
      4'b0100: begin hsize_o = HSIZE_BYTE; offset_o = 2'd2; end
      4'b1000: begin hsize_o = HSIZE_BYTE; offset_o = 2'd3; end
      4'b0011: begin hsize_o = HSIZE_HALF; offset_o = 2'd0; end
      4'b1100: begin hsize_o = HSIZE_HALF; offset_o = 2'd2; end
      default: begin hsize_o = HSIZE_WORD; offset_o = 2'd0; end
    endcase
  end

endmodule

// File: rtl/obi_ahb_master_bridge.sv
// obi_ahb_master_bridge: converts one OBI core port (req/gnt/rvalid) into a
// single-master AHB-Lite transfer stream, one outstanding transfer at most.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i/gnt_o                   OBI address-phase handshake
//   addr_i, we_i, be_i, wdata_i   OBI request payload
//   rvalid_o, rdata_o, err_o      OBI response (one per granted request)
//   haddr_o..hprot_o, hwdata_o    AHB master outputs
//   hrdata_i, hready_i, hresp_i   AHB slave response
//   state_o                       FSM state, debug visibility
// Handshakes: an OBI request transfers on a cycle where req_i and gnt_o are
// both high; gnt_o only rises when the AHB address phase is accepted
// (hready_i=1), so grant and AHB address acceptance are the same event.
// The response appears on rvalid_o for exactly one cycle and cannot be
// back-pressured.
module obi_ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter bit IS_INSTR = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i,
  output logic [1:0]  state_o
);

  bridge_state_t state_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [2:0]    dec_hsize;
  logic [1:0]    dec_offset;
  logic          accepting;
  logic          addr_phase;
  logic          addr_lsb_unused;

  obi_ahb_size_decode u_size_decode (
    .be_i     (be_i),
    .hsize_o  (dec_hsize),
    .offset_o (dec_offset)
  );

  // The low address bits come from the byte enables, not from addr_i.
  assign addr_lsb_unused = ^addr_i[1:0];

  // RESP behaves like IDLE for a new request, giving 2-cycle throughput.
  assign accepting  = (state_q == BR_IDLE) || (state_q == BR_RESP);
  assign addr_phase = accepting && req_i;

  // Masking with rst_i keeps the core from seeing a grant that reset discards.
  assign gnt_o    = addr_phase && hready_i && !rst_i;

  // Address-phase signals are zeroed when no transfer is requested so the
  // bus sits at its reset values while idle.
  assign htrans_o = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = addr_phase ? {addr_i[31:2], dec_offset} : 32'd0;
  assign hwrite_o = addr_phase && we_i;
  assign hsize_o  = addr_phase ? dec_hsize : HSIZE_WORD;
  assign hburst_o = HBURST_SINGLE;
  assign hprot_o  = IS_INSTR ? 4'b0010 : 4'b0011;
  assign hwdata_o = (state_q == BR_DATA) ? wdata_q : 32'd0;

  assign rvalid_o = (state_q == BR_RESP);
  assign rdata_o  = rvalid_o ? rdata_q : 32'd0;
  assign err_o    = rvalid_o && err_q;
  assign state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BR_IDLE;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        BR_IDLE, BR_RESP: begin
          if (gnt_o) begin
            state_q <= BR_DATA;
            we_q    <= we_i;
            wdata_q <= wdata_i;
          end else begin
            state_q <= BR_IDLE;
          end
        end
        BR_DATA: begin
          // The first ERROR cycle has hready_i=0 and simply waits here;
          // the completing cycle carries hresp_i=1 into err_q.
          if (hready_i) begin
            rdata_q <= (!we_q && !hresp_i) ? hrdata_i : 32'd0;
            err_q   <= hresp_i;
            state_q <= BR_RESP;
          end
        end
        default: state_q <= BR_IDLE;
      endcase
    end
  end

endmodule
